// File: rtl/if_fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: default widths, start PC,
// halt encoding, FSM state encoding and fetch-queue depth.
package if_fetch_unit_pkg;

  localparam int          ADDR_W_DEF    = 19;
  localparam int          START_PC_DEF  = 1;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam int          Q_DEPTH       = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/if_fetch_queue.sv
// Two-entry in-order FIFO of {pc, inst} between the i-cache return and decode.
// Entry 0 is always the head; flush overrides push and pop.
module if_fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [31:0]       push_inst,
  input  logic              pop,
  input  logic              flush,
  output logic              head_vld,
  output logic [ADDR_W-1:0] head_pc,
  output logic [31:0]       head_inst,
  output logic [1:0]        occ
);

  logic [ADDR_W-1:0] pc0, pc1;
  logic [31:0]       inst0, inst1;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ   <= 2'd0;
      pc0   <= '0;
      pc1   <= '0;
      inst0 <= '0;
      inst1 <= '0;
    end else if (flush) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            pc0   <= push_pc;
            inst0 <= push_inst;
          end else begin
            pc1   <= push_pc;
            inst1 <= push_inst;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          pc0   <= pc1;
          inst0 <= inst1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          // simultaneous push/pop: the new word lands behind whatever survives
          if (occ == 2'd1) begin
            pc0   <= push_pc;
            inst0 <= push_inst;
          end else begin
            pc0   <= pc1;
            inst0 <= inst1;
            pc1   <= push_pc;
            inst1 <= push_inst;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_vld  = (occ != 2'd0);
  assign head_pc   = pc0;
  assign head_inst = inst0;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues PCs to a 1-cycle i-cache, queues returns, feeds decode.
// Optional IF_FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt counters.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter int          START_PC  = START_PC_DEF,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_busy,
  output logic              im_en,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halt
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              vld_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic [1:0]        occ;
  logic [2:0]        lvl;
  logic              run, kill, pop, q_pop, halt_pop, push;

  assign run      = (state == ST_RUN);
  assign kill     = run && redirect;
  assign pop      = if_valid && !stall;
  assign q_pop    = pop && !kill;
  assign halt_pop = run && q_pop && (if_inst == HALT_WORD);
  // occupancy after this cycle's pop plus the read already in flight
  assign lvl      = 3'(occ) - 3'(pop) + 3'(vld_p1);
  assign im_en    = run && !load_busy && !redirect && (lvl < 3'(Q_DEPTH));
  assign im_addr  = im_en ? pc : '0;
  assign push     = run && vld_p1 && !kill && !halt_pop;
  assign halt     = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= ADDR_W'(START_PC);
    end else begin
      case (state)
        ST_IDLE: if (start && !load_busy) state <= ST_RUN;
        ST_RUN: begin
          if (redirect) begin
            pc <= redirect_pc;
          end else begin
            if (im_en) pc <= pc + ADDR_W'(1);
            if (halt_pop) state <= ST_HALT;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- stage p1: i-cache read in flight, data returns this cycle ----
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= im_en;
  end

  always_ff @(posedge clk) begin
    pc_p1 <= pc;
  end

  if_fetch_queue #(.ADDR_W(ADDR_W)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_pc   (pc_p1),
    .push_inst (im_rdata),
    .pop       (q_pop),
    .flush     (kill || halt_pop),
    .head_vld  (if_valid),
    .head_pc   (if_pc),
    .head_inst (if_inst),
    .occ       (occ)
  );

`ifdef IF_FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (q_pop)              perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
      if (if_valid && stall)  perf_stall_cnt <= sat_inc(perf_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural i-cache, program-order stream model,
// and directed scenarios with hand-computed cycle-exact expectations.
module tb_if_fetch_unit;
  localparam int          AW = 19;
  localparam logic [31:0] HW = 32'hFFFF_FFFF;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, load_busy, stall, redirect;
  logic [AW-1:0] redirect_pc;
  logic [31:0]   im_rdata = 32'h0;
  logic          im_en, if_valid, halt;
  logic [AW-1:0] im_addr, if_pc;
  logic [31:0]   if_inst;
`ifdef IF_FETCH_PERF_EN
  logic [31:0]   perf_fetch_cnt, perf_stall_cnt;
`endif

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .load_busy(load_busy),
    .im_en(im_en), .im_addr(im_addr), .im_rdata(im_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .halt(halt)
`ifdef IF_FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int checks = 0, errors = 0;
  logic [31:0] ovr [int];

  function automatic logic [31:0] word(input logic [AW-1:0] a);
    if (ovr.exists(int'(a))) return ovr[int'(a)];
    return 32'h5000_0000 | 32'(a);
  endfunction

  // i-cache: synchronous read, one cycle latency
  always @(posedge clk) if (im_en) im_rdata <= word(im_addr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic exp_if(input string tag, input logic v, input logic [AW-1:0] pc, input logic [31:0] inst);
    chk({tag, "_valid"}, 64'(if_valid), 64'(v));
    if (v) begin
      chk({tag, "_pc"}, 64'(if_pc), 64'(pc));
      chk({tag, "_inst"}, 64'(if_inst), 64'(inst));
    end
  endtask

  task automatic nxt;
    @(posedge clk); #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask

  // program-order stream model, checked every cycle
  logic          mon_en = 1'b0;
  int            m_st = M_IDLE;
  logic [AW-1:0] exp_pc = AW'(1), iss_pc = AW'(1);
  logic          hold_p = 1'b0, redir_p = 1'b0;
  logic [AW-1:0] hold_pc;
  logic [31:0]   hold_inst;
  int            m_pops = 0, m_stl = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (m_st != M_RUN) begin
          chk("im_en_not_run", 64'(im_en), 64'(0));
          chk("if_valid_not_run", 64'(if_valid), 64'(0));
        end
        chk("halt_flag", 64'(halt), 64'(m_st == M_HALT));
        if (load_busy || redirect) chk("im_en_blocked", 64'(im_en), 64'(0));
        if (im_en === 1'b1) chk("im_addr_seq", 64'(im_addr), 64'(iss_pc));
        if (redir_p) chk("flush_after_redirect", 64'(if_valid), 64'(0));
        if (hold_p) begin
          chk("stall_hold_valid", 64'(if_valid), 64'(1));
          chk("stall_hold_pc", 64'(if_pc), 64'(hold_pc));
          chk("stall_hold_inst", 64'(if_inst), 64'(hold_inst));
        end
        if (m_st == M_RUN && if_valid === 1'b1) begin
          chk("stream_pc", 64'(if_pc), 64'(exp_pc));
          chk("stream_inst", 64'(if_inst), 64'(word(exp_pc)));
        end
`ifdef IF_FETCH_PERF_EN
        chk("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'(m_pops));
        chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stl));
`endif
        hold_p  = 1'b0;
        redir_p = 1'b0;
        if (rst) begin
          m_st = M_IDLE; exp_pc = AW'(1); iss_pc = AW'(1); m_pops = 0; m_stl = 0;
        end else begin
          if (if_valid && stall) m_stl++;
          if (m_st == M_IDLE) begin
            if (start && !load_busy) m_st = M_RUN;
          end else if (m_st == M_RUN) begin
            if (redirect) begin
              exp_pc = redirect_pc; iss_pc = redirect_pc; redir_p = 1'b1;
            end else begin
              if (im_en) iss_pc = iss_pc + AW'(1);
              if (if_valid && !stall) begin
                m_pops++;
                if (word(exp_pc) == HW) m_st = M_HALT;
                exp_pc = exp_pc + AW'(1);
              end
              hold_p = if_valid && stall; hold_pc = if_pc; hold_inst = if_inst;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; load_busy = 1'b0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    nxt; nxt; mon_en = 1'b1;
    smp;
    chk("rst_im_en", 64'(im_en), 64'(0));
    chk("rst_im_addr", 64'(im_addr), 64'(0));
    chk("rst_if_valid", 64'(if_valid), 64'(0));
    chk("rst_if_inst", 64'(if_inst), 64'(0));
    chk("rst_if_pc", 64'(if_pc), 64'(0));
    chk("rst_halt", 64'(halt), 64'(0));

    // load A0..A5 at 1..6 with start already high
    for (int i = 1; i <= 6; i++) begin
      nxt; rst = 1'b0; start = 1'b1; load_busy = 1'b1;
      ovr[i] = 32'hA000_00A0 + 32'(i - 1);
      smp; chk("im_en_loading", 64'(im_en), 64'(0));
    end
    nxt; load_busy = 1'b0; smp; chk("idle_c0_im_en", 64'(im_en), 64'(0));
    nxt; smp;
    chk("c1_im_en", 64'(im_en), 64'(1));
    chk("c1_im_addr", 64'(im_addr), 64'(1));
    exp_if("c1", 1'b0, '0, '0);
    nxt; smp; exp_if("c2", 1'b0, '0, '0);
    nxt; smp; exp_if("c3", 1'b1, 19'h1, 32'hA000_00A0);
    nxt; smp; exp_if("c4", 1'b1, 19'h2, 32'hA000_00A1);

    // stall 4 cycles with pc=3 at head
    for (int k = 0; k < 4; k++) begin
      nxt; stall = 1'b1; smp;
      exp_if("stall", 1'b1, 19'h3, 32'hA000_00A2);
      chk("stall_im_en", 64'(im_en), 64'(0));
    end
    nxt; stall = 1'b0; smp;
    exp_if("c9", 1'b1, 19'h3, 32'hA000_00A2);
    chk("c9_im_en", 64'(im_en), 64'(1));
    chk("c9_im_addr", 64'(im_addr), 64'(5));

    // redirect to 0x10 while pc=5 is returning
    nxt; redirect = 1'b1; redirect_pc = 19'h10; smp;
    chk("c10_im_en", 64'(im_en), 64'(0));
    exp_if("c10", 1'b1, 19'h4, 32'hA000_00A3);
    nxt; redirect = 1'b0; smp;
    exp_if("c11", 1'b0, '0, '0);
    chk("c11_im_addr", 64'(im_addr), 64'(19'h10));
    nxt; smp; exp_if("c12", 1'b0, '0, '0);
    nxt; smp; exp_if("c13", 1'b1, 19'h10, 32'h5000_0010);
    nxt; smp; exp_if("c14", 1'b1, 19'h11, 32'h5000_0011);

    // wrap at top of address space
    nxt; redirect = 1'b1; redirect_pc = 19'h7FFFF; smp;
    nxt; redirect = 1'b0; smp;
    exp_if("d1", 1'b0, '0, '0);
    chk("d1_im_addr", 64'(im_addr), 64'(19'h7FFFF));
    nxt; smp; chk("d2_im_addr", 64'(im_addr), 64'(0));
    nxt; smp; exp_if("d3", 1'b1, 19'h7FFFF, 32'h5007_FFFF);
    nxt; smp; exp_if("d4", 1'b1, 19'h0, 32'h5000_0000);
    nxt; smp; exp_if("d5", 1'b1, 19'h1, 32'hA000_00A0);

    // reset pulse mid-stream while stalled
    nxt; stall = 1'b1; smp; exp_if("d6", 1'b1, 19'h2, 32'hA000_00A1);
    nxt; smp; exp_if("d7", 1'b1, 19'h2, 32'hA000_00A1);
    nxt; rst = 1'b1; smp; exp_if("rst_cyc", 1'b1, 19'h2, 32'hA000_00A1);
    nxt; rst = 1'b0; stall = 1'b0; smp;
    chk("r1_if_valid", 64'(if_valid), 64'(0));
    chk("r1_if_pc", 64'(if_pc), 64'(0));
    chk("r1_if_inst", 64'(if_inst), 64'(0));
    chk("r1_im_en", 64'(im_en), 64'(0));
    chk("r1_halt", 64'(halt), 64'(0));
    nxt; smp;
    chk("r2_im_en", 64'(im_en), 64'(1));
    chk("r2_im_addr", 64'(im_addr), 64'(1));

    // halt word at pc=4, written before it is fetched
    nxt; ovr[4] = HW; smp;
    nxt; smp; exp_if("r4", 1'b1, 19'h1, 32'hA000_00A0);
    nxt; smp; exp_if("r5", 1'b1, 19'h2, 32'hA000_00A1);
    nxt; smp; exp_if("r6", 1'b1, 19'h3, 32'hA000_00A2);
    nxt; smp; exp_if("r7", 1'b1, 19'h4, 32'hFFFF_FFFF);
    chk("r7_halt", 64'(halt), 64'(0));
    nxt; smp;
    chk("r8_halt", 64'(halt), 64'(1));
    chk("r8_if_valid", 64'(if_valid), 64'(0));
    chk("r8_im_en", 64'(im_en), 64'(0));
    nxt; redirect = 1'b1; redirect_pc = 19'h20; smp;
    chk("r9_halt", 64'(halt), 64'(1));
    nxt; redirect = 1'b0; smp;
    for (int k = 0; k < 3; k++) begin
      chk("halt_hold", 64'(halt), 64'(1));
      chk("halt_if_valid", 64'(if_valid), 64'(0));
      chk("halt_im_en", 64'(im_en), 64'(0));
      nxt; smp;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
